// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch reads and execute loads/posted stores.
// Latency: grant one cycle after request in IDLE; fin combinational with m_ack (2 cycles min).
// Backpressure: requests wait while any access is in flight; a buffered store goes before any new grant.
module mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int READ_ADDR_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // fetch stage
    input  logic                      f_readEn,
    input  logic [READ_ADDR_SIZE-1:0] f_readAddr,
    output logic                      f_readFin,
    output logic [XLEN-1:0]           f_readData,
    // execute stage
    input  logic                      e_readEn,
    input  logic [READ_ADDR_SIZE-1:0] e_readAddr,
    output logic                      e_readFin,
    output logic [XLEN-1:0]           e_readData,
    input  logic                      e_writeEn,
    input  logic [READ_ADDR_SIZE-1:0] e_writeAddr,
    input  logic [XLEN-1:0]           e_writeData,
    // memory port
    output logic                      m_req,
    output logic                      m_we,
    output logic [READ_ADDR_SIZE-1:0] m_addr,
    output logic [XLEN-1:0]           m_wdata,
    input  logic                      m_ack,
    input  logic [XLEN-1:0]           m_rdata
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        F_RD = 4'b0010,
        E_RD = 4'b0100,
        E_WR = 4'b1000
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [READ_ADDR_SIZE-1:0] addr_q;
    logic                      wb_valid;
    logic [READ_ADDR_SIZE-1:0] wb_addr;
    logic [XLEN-1:0]           wb_data;
    logic                      last_grant;   // 0 = fetch, 1 = execute

    logic                      grant_f;
    logic                      grant_e;
    logic                      wb_load;
    logic                      wb_clr;
    logic                      lg_fetch;
    logic                      lg_exec;

    // State register and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            last_grant <= 1'b1;          // fetch wins the first tie
        end else begin
            state <= next_state;
            if (grant_f)
                addr_q <= f_readAddr;
            else if (grant_e)
                addr_q <= e_readAddr;
            if (lg_fetch)
                last_grant <= 1'b0;
            else if (lg_exec)
                last_grant <= 1'b1;
            if (wb_load) begin
                wb_valid <= 1'b1;
                wb_addr  <= e_writeAddr;
                wb_data  <= e_writeData;
            end else if (wb_clr) begin
                wb_valid <= 1'b0;
            end
        end
    end

    // Next-state, grant decision and memory/requester outputs.
    always_comb begin
        next_state = state;
        grant_f    = 1'b0;
        grant_e    = 1'b0;
        wb_load    = 1'b0;
        wb_clr     = 1'b0;
        lg_fetch   = 1'b0;
        lg_exec    = 1'b0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        f_readFin  = 1'b0;
        f_readData = '0;
        e_readFin  = 1'b0;
        e_readData = '0;

        case (state)
            IDLE: begin
                // A posted store always drains before anyone else is granted.
                if (wb_valid) begin
                    next_state = E_WR;
                end else if (f_readEn && e_readEn) begin
                    if (last_grant) begin
                        grant_f    = 1'b1;
                        next_state = F_RD;
                    end else begin
                        grant_e    = 1'b1;
                        next_state = E_RD;
                    end
                end else if (f_readEn) begin
                    grant_f    = 1'b1;
                    next_state = F_RD;
                end else if (e_readEn) begin
                    grant_e    = 1'b1;
                    next_state = E_RD;
                end
            end

            F_RD: begin
                m_req      = 1'b1;
                m_addr     = addr_q;
                f_readData = m_rdata;
                if (m_ack) begin
                    // A withdrawn requester gets no pulse; the access still completes.
                    f_readFin  = f_readEn;
                    lg_fetch   = 1'b1;
                    next_state = IDLE;
                end
            end

            E_RD: begin
                m_req      = 1'b1;
                m_addr     = addr_q;
                e_readData = m_rdata;
                if (m_ack) begin
                    e_readFin = e_readEn;
                    lg_exec   = 1'b1;
                    // Store data is only taken in the fin cycle; goes straight to write with no IDLE gap.
                    if (e_readEn && e_writeEn) begin
                        wb_load    = 1'b1;
                        next_state = E_WR;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            E_WR: begin
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = wb_addr;
                m_wdata = wb_data;
                if (m_ack) begin
                    wb_clr     = 1'b1;
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, tie-break, posted store, withdrawal, reset mid-write.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory and acks on fixed, hand-chosen cycles.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_readEn;
    logic [31:0] f_readAddr;
    logic        f_readFin;
    logic [31:0] f_readData;
    logic        e_readEn;
    logic [31:0] e_readAddr;
    logic        e_readFin;
    logic [31:0] e_readData;
    logic        e_writeEn;
    logic [31:0] e_writeAddr;
    logic [31:0] e_writeData;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int n_tests;
    int n_fail;

    mem_arbiter #(.XLEN(32), .READ_ADDR_SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_readEn    (f_readEn),
        .f_readAddr  (f_readAddr),
        .f_readFin   (f_readFin),
        .f_readData  (f_readData),
        .e_readEn    (e_readEn),
        .e_readAddr  (e_readAddr),
        .e_readFin   (e_readFin),
        .e_readData  (e_readData),
        .e_writeEn   (e_writeEn),
        .e_writeAddr (e_writeAddr),
        .e_writeData (e_writeData),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        f_readEn    = 1'b0;
        f_readAddr  = '0;
        e_readEn    = 1'b0;
        e_readAddr  = '0;
        e_writeEn   = 1'b0;
        e_writeAddr = '0;
        e_writeData = '0;
        m_ack       = 1'b0;
        m_rdata     = '0;

        // ---- reset state ----
        #12;
        chk("rst_m_req",   {31'd0, m_req},     32'd0);
        chk("rst_m_we",    {31'd0, m_we},      32'd0);
        chk("rst_m_addr",  m_addr,             32'd0);
        chk("rst_m_wdata", m_wdata,            32'd0);
        chk("rst_f_fin",   {31'd0, f_readFin}, 32'd0);
        chk("rst_e_fin",   {31'd0, e_readFin}, 32'd0);
        chk("rst_f_data",  f_readData,         32'd0);
        chk("rst_e_data",  e_readData,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- fetch only, zero-wait memory ----
        tick(); f_readEn = 1'b1; f_readAddr = 32'h100;
        sample(); chk("fo_c0_req", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        sample();
        chk("fo_c1_req",  {31'd0, m_req},     32'd1);
        chk("fo_c1_addr", m_addr,             32'h100);
        chk("fo_c1_we",   {31'd0, m_we},      32'd0);
        chk("fo_c1_fin",  {31'd0, f_readFin}, 32'd1);
        chk("fo_c1_data", f_readData,         32'hDEADBEEF);
        tick(); m_ack = 1'b0; f_readEn = 1'b0;
        sample();
        chk("fo_c2_idle", {31'd0, m_req}, 32'd0);
        chk("fo_c2_data", f_readData,     32'd0);

        // ---- tie-break after reset: fetch, execute, fetch ----
        pulse_reset();
        tick(); f_readEn = 1'b1; f_readAddr = 32'h200; e_readEn = 1'b1; e_readAddr = 32'h300;
        sample(); chk("tie_c0_req", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'hA0A0A0A0;
        sample();
        chk("tie1_addr",  m_addr,             32'h200);
        chk("tie1_ffin",  {31'd0, f_readFin}, 32'd1);
        chk("tie1_efin",  {31'd0, e_readFin}, 32'd0);
        chk("tie1_fdata", f_readData,         32'hA0A0A0A0);
        tick(); m_ack = 1'b0; f_readAddr = 32'h204;
        sample(); chk("tie1_gap", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'h00000055;
        sample();
        chk("tie2_addr",  m_addr,             32'h300);
        chk("tie2_efin",  {31'd0, e_readFin}, 32'd1);
        chk("tie2_ffin",  {31'd0, f_readFin}, 32'd0);
        chk("tie2_edata", e_readData,         32'h00000055);
        tick(); m_ack = 1'b0; e_readAddr = 32'h304;
        sample(); chk("tie2_gap", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'h00000077;
        sample();
        chk("tie3_addr", m_addr,             32'h204);
        chk("tie3_ffin", {31'd0, f_readFin}, 32'd1);
        tick(); m_ack = 1'b0; f_readEn = 1'b0; e_readEn = 1'b0;
        sample(); chk("tie3_idle", {31'd0, m_req}, 32'd0);

        // ---- execute store with a concurrent fetch ----
        tick(); e_readEn = 1'b1; e_readAddr = 32'h400;
        sample();
        tick(); m_ack = 1'b1; m_rdata = 32'h11223344;
        e_writeEn = 1'b1; e_writeAddr = 32'h400; e_writeData = 32'h112233AA;
        f_readEn = 1'b1; f_readAddr = 32'h500;
        sample();
        chk("st_efin",  {31'd0, e_readFin}, 32'd1);
        chk("st_edata", e_readData,         32'h11223344);
        chk("st_rd_we", {31'd0, m_we},      32'd0);
        tick(); m_ack = 1'b0; e_writeEn = 1'b0; e_readEn = 1'b0;
        sample();
        chk("st_wr_req",   {31'd0, m_req},     32'd1);
        chk("st_wr_we",    {31'd0, m_we},      32'd1);
        chk("st_wr_addr",  m_addr,             32'h400);
        chk("st_wr_wdata", m_wdata,            32'h112233AA);
        chk("st_wr_ffin",  {31'd0, f_readFin}, 32'd0);
        tick(); m_ack = 1'b1;
        sample();
        chk("st_ack_we",   {31'd0, m_we},      32'd1);
        chk("st_ack_ffin", {31'd0, f_readFin}, 32'd0);
        tick(); m_ack = 1'b0;
        sample(); chk("st_idle", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'h00000099;
        sample();
        chk("st_f_addr", m_addr,             32'h500);
        chk("st_f_we",   {31'd0, m_we},      32'd0);
        chk("st_f_fin",  {31'd0, f_readFin}, 32'd1);
        tick(); m_ack = 1'b0; f_readEn = 1'b0;
        sample();

        // ---- e_writeEn outside the fin cycle is ignored ----
        tick(); e_readEn = 1'b1; e_readAddr = 32'h700;
        sample();
        tick(); e_writeEn = 1'b1; e_writeAddr = 32'h700; e_writeData = 32'h00000BAD;
        sample(); chk("ig_wait_req", {31'd0, m_req}, 32'd1);
        tick(); e_writeEn = 1'b0; m_ack = 1'b1; m_rdata = 32'h00000001;
        sample(); chk("ig_efin", {31'd0, e_readFin}, 32'd1);
        tick(); m_ack = 1'b0; e_readEn = 1'b0;
        sample(); chk("ig_no_write", {31'd0, m_req}, 32'd0);

        // ---- fetch withdraws during 3 wait cycles ----
        tick(); f_readEn = 1'b1; f_readAddr = 32'h600;
        sample();
        tick();
        sample(); chk("wd_w1_req", {31'd0, m_req}, 32'd1);
        tick(); f_readEn = 1'b0;
        sample();
        chk("wd_w2_req", {31'd0, m_req},     32'd1);
        chk("wd_w2_fin", {31'd0, f_readFin}, 32'd0);
        tick();
        sample(); chk("wd_w3_req", {31'd0, m_req}, 32'd1);
        tick(); m_ack = 1'b1; m_rdata = 32'h0000CAFE;
        sample();
        chk("wd_ack_req",  {31'd0, m_req},     32'd1);
        chk("wd_ack_addr", m_addr,             32'h600);
        chk("wd_ack_fin",  {31'd0, f_readFin}, 32'd0);
        tick(); m_ack = 1'b0;
        sample(); chk("wd_idle", {31'd0, m_req}, 32'd0);

        // ---- stray ack while idle ----
        tick(); m_ack = 1'b1;
        sample();
        chk("stray_ffin", {31'd0, f_readFin}, 32'd0);
        chk("stray_efin", {31'd0, e_readFin}, 32'd0);
        tick(); m_ack = 1'b0;
        sample(); chk("stray_req", {31'd0, m_req}, 32'd0);

        // ---- reset during E_WR with ack pending ----
        tick(); e_readEn = 1'b1; e_readAddr = 32'h800;
        sample();
        tick(); m_ack = 1'b1; m_rdata = 32'h0;
        e_writeEn = 1'b1; e_writeAddr = 32'h800; e_writeData = 32'h00001234;
        sample();
        tick(); m_ack = 1'b0; e_writeEn = 1'b0; e_readEn = 1'b0;
        sample(); chk("rw_we_before", {31'd0, m_we}, 32'd1);
        tick(); m_ack = 1'b1;
        #1; rst = 1'b1;
        #1;
        chk("rw_req",   {31'd0, m_req},        32'd0);
        chk("rw_we",    {31'd0, m_we},         32'd0);
        chk("rw_wbval", {31'd0, dut.wb_valid}, 32'd0);
        m_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(); f_readEn = 1'b1; f_readAddr = 32'h40;
        sample(); chk("rw_f_c0", {31'd0, m_req}, 32'd0);
        tick(); m_ack = 1'b1; m_rdata = 32'h00004040;
        sample();
        chk("rw_f_addr", m_addr,             32'h40);
        chk("rw_f_we",   {31'd0, m_we},      32'd0);
        chk("rw_f_fin",  {31'd0, f_readFin}, 32'd1);
        chk("rw_f_data", f_readData,         32'h00004040);
        tick(); m_ack = 1'b0; f_readEn = 1'b0;
        sample(); chk("rw_f_idle", {31'd0, m_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data/instruction memory port between the fetch stage (read-only) and the execute stage (load, or read-modify-write store). It grants one requester at a time using round-robin arbitration and runs each access as a held request/acknowledge transaction. Stores are posted: the execute stage's single-cycle write pulse is buffered and issued before any new grant. The block sits between the pipeline stages and the memory model.

## Interface
- `XLEN`, 32, data width
- `READ_ADDR_SIZE`, 32, address width
- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `f_readEn` in 1 — fetch read request, level, held until `f_readFin`
- `f_readAddr` in READ_ADDR_SIZE — fetch address
- `f_readFin` out 1 — fetch read done, 1-cycle pulse
- `f_readData` out XLEN — fetch read data, valid with `f_readFin`
- `e_readEn` in 1 — execute read request, level, held until `e_readFin`
- `e_readAddr` in READ_ADDR_SIZE — execute address
- `e_readFin` out 1 — execute read done, 1-cycle pulse
- `e_readData` out XLEN — execute read data, valid with `e_readFin`
- `e_writeEn` in 1 — execute store pulse; honoured only in the `e_readFin` cycle
- `e_writeAddr` in READ_ADDR_SIZE — store address
- `e_writeData` in XLEN — store data (merged word)
- `m_req` out 1 — memory request, held until `m_ack`
- `m_we` out 1 — memory write select
- `m_addr` out READ_ADDR_SIZE — memory address
- `m_wdata` out XLEN — memory write data
- `m_ack` in 1 — memory done, 1-cycle pulse, allowed in any cycle that `m_req` is high, including the first
- `m_rdata` in XLEN — memory read data, valid with `m_ack`

## Operation
- State register, one-hot: IDLE, F_RD, E_RD, E_WR.
- Registers:
  - `addr_q`: latched at grant.
  - write buffer: `wb_valid`, `wb_addr`, `wb_data`.
  - `last_grant`: 0 = fetch, 1 = execute.
- IDLE, evaluated in this order:
  - `wb_valid` → E_WR.
  - Both `e_readEn` and `f_readEn` → grant the requester that is not `last_grant`.
  - Only one request → grant it.
  - Otherwise stay in IDLE.
  - On a grant, `addr_q` <= the granted requester's address.
- F_RD:
  - `m_req`=1, `m_we`=0, `m_addr`=`addr_q`.
  - On `m_ack`: `f_readFin` = `f_readEn`; `f_readData`=`m_rdata` (combinational); `last_grant`<=0; → IDLE.
- E_RD:
  - Same as F_RD, using the execute outputs.
  - On `m_ack`: `last_grant`<=1.
  - If `e_writeEn` is also high in the `e_readFin` cycle: latch `wb_addr`/`wb_data`, set `wb_valid`, → E_WR. Otherwise → IDLE.
- E_WR:
  - `m_req`=1, `m_we`=1, `m_addr`=`wb_addr`, `m_wdata`=`wb_data`.
  - On `m_ack`: clear `wb_valid`; → IDLE.
  - No requester is notified.
- Requester withdrawal: if a requester drops its read enable before ack, the memory transaction still completes (`m_req` stays high). The fin pulse is suppressed and the data is discarded.
- `e_writeEn` outside the `e_readFin` cycle is ignored.
- While in any non-IDLE state, new requests wait. There is no pre-emption.
- `f_readData`/`e_readData` = `m_rdata` when in their read state, else 0.
- `m_wdata` = 0 outside E_WR. `m_addr` = 0 in IDLE.

## Timing
- Reset values, forced asynchronously on `rst` assertion:
  - state IDLE, `wb_valid` 0, `addr_q`/`wb_addr`/`wb_data` 0, `last_grant` 1 (fetch wins the first tie).
  - All outputs 0.
- A request high at edge t (state IDLE) → `m_req` high from cycle t+1.
- Zero-wait memory: `m_ack` in cycle t+1 gives fin in cycle t+1, i.e. minimum read latency is 2 cycles from request to fin.
- Back-to-back: after fin the state returns to IDLE for one cycle; the next grant issues the following cycle. Throughput is one access per 2 cycles, plus memory wait.
- Store: the write occupies the port immediately after the load phase with no IDLE gap. The execute stage is released at `e_readFin` and does not wait for the write.
- A fetch request pending during E_RD→E_WR is served only after the write completes (write-buffer priority).
- Reset mid-transaction: everything is abandoned and `m_req` drops immediately. The memory must tolerate a dropped request.
- `m_ack` while `m_req` is low is ignored.

## Test plan
- Reset during E_WR with `m_ack` pending → `m_req`, `m_we` and `wb_valid` all fall to 0 asynchronously; after release, a fetch at 0x40 is served normally.
- Fetch-only, `f_readAddr`=0x100, memory acks in the first cycle with 0xDEADBEEF → `m_req` cycle 1, `f_readFin` cycle 1, `f_readData`=0xDEADBEEF, state IDLE at cycle 2.
- Simultaneous fetch 0x200 and execute 0x300 requests after reset → fetch granted first. Execute is granted after fetch completes, and the next tie goes to fetch again.
- Execute store: read 0x400 acks with 0x11223344 while `e_writeEn`=1, `e_writeData`=0x112233AA → next cycle `m_we`=1, `m_addr`=0x400, `m_wdata`=0x112233AA. A concurrent fetch waits until the write ack.
- Memory with 3 wait cycles, then fetch drops `f_readEn` mid-wait → `m_req` held through the ack, `f_readFin` stays 0, return to IDLE.
